// File: rtl/branch_pkg.sv
// Shared encodings and helpers for the branch redirect path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package branch_pkg;

  // Controller states; encoding is visible to other units, so keep it fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of the post-acceptance drain counter (drain length 0..15).
  localparam int FLUSH_CNT_W = 4;

  // Jump targets must be word aligned; any set low bit is a misalignment.
  function automatic logic target_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/perf_counter32.sv
// 32-bit wrap-around event counter with increment enable.
// Latency: an enabled increment is visible on o_count one cycle later.
// Backpressure: none; counts every enabled cycle.
module perf_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // Count enabled cycles; the 32-bit add overflows naturally from all-ones to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Registers the branch unit's jump decision into a held fetch redirect, flushes IF/ID, drains, flags misaligned targets.
// Latency: branch event in cycle C gives redirect_valid / flush_ifid / counter update at C+1.
// Backpressure: redirect held until redirect_ready; ex_ready is low outside IDLE so upstream stalls EX.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            jmp_en,
  input  logic            b_n_jmp,
  input  logic            branch_hazard,
  input  logic [XLEN-1:0] pc_cur,
  input  logic [XLEN-1:0] pc_target,
  input  logic            ext_flush,
  input  logic            redirect_ready,
  output logic            ex_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic            exc_misalign,
  output logic [XLEN-1:0] exc_pc,
  output logic [XLEN-1:0] exc_tval,
  output logic [31:0]     cnt_taken,
  output logic [31:0]     cnt_not_taken
);

  import branch_pkg::*;

  localparam logic [FLUSH_CNT_W-1:0] LP_FLUSH = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [FLUSH_CNT_W-1:0] r_drain_cnt;
  logic                   r_redirect_vld;
  logic [XLEN-1:0]        r_redirect_pc;
  logic                   r_flush_ifid;
  logic                   r_exc_misalign;
  logic [XLEN-1:0]        r_exc_pc;
  logic [XLEN-1:0]        r_exc_tval;

  logic w_event;
  logic w_taken;
  logic w_misalign;
  logic w_redirect;
  logic w_not_taken;
  logic w_handshake;

  // A trap flush in the same cycle swallows the event entirely: no pulse, no count.
  // jmp_en wins over b_n_jmp if the branch unit ever raises both.
  assign ex_ready    = (r_state == ST_IDLE);
  assign w_event     = ex_valid & ~branch_hazard & ex_ready & ~ext_flush;
  assign w_taken     = w_event & jmp_en;
  assign w_misalign  = w_taken & target_misaligned(pc_target[1:0]);
  assign w_redirect  = w_taken & ~target_misaligned(pc_target[1:0]);
  assign w_not_taken = w_event & ~jmp_en & b_n_jmp;
  assign w_handshake = r_redirect_vld & redirect_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; ext_flush overrides every transition.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_redirect) w_next_state = ST_REDIR;
      end
      ST_REDIR: begin
        if (w_handshake) w_next_state = (FLUSH_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_cnt <= FLUSH_CNT_W'(1)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (ext_flush) w_next_state = ST_IDLE;
  end

  // Drain counter: loaded on redirect acceptance, counts down through DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (ext_flush) begin
      r_drain_cnt <= '0;
    end else if ((r_state == ST_REDIR) && w_handshake) begin
      r_drain_cnt <= LP_FLUSH;
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Registered redirect, flush pulse and exception outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_vld <= 1'b0;
      r_redirect_pc  <= '0;
      r_flush_ifid   <= 1'b0;
      r_exc_misalign <= 1'b0;
      r_exc_pc       <= '0;
      r_exc_tval     <= '0;
    end else begin
      r_redirect_vld <= (w_next_state == ST_REDIR);
      r_flush_ifid   <= w_redirect;
      r_exc_misalign <= w_misalign;
      // Target only loads from IDLE, so it stays stable for the whole REDIR hold.
      if (w_redirect) r_redirect_pc <= pc_target;
      if (w_misalign) begin
        r_exc_pc   <= pc_cur;
        r_exc_tval <= pc_target;
      end
    end
  end

  assign redirect_valid = r_redirect_vld;
  assign redirect_pc    = r_redirect_pc;
  assign flush_ifid     = r_flush_ifid;
  assign exc_misalign   = r_exc_misalign;
  assign exc_pc         = r_exc_pc;
  assign exc_tval       = r_exc_tval;

  perf_counter32 u_cnt_taken (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_redirect),
    .o_count (cnt_taken)
  );

  perf_counter32 u_cnt_not_taken (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_not_taken),
    .o_count (cnt_not_taken)
  );

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sits directly downstream of the branch execute unit and turns its combinational jump decision into a registered, handshaked redirect to the fetch stage. On a taken jump it captures the target, flushes the younger IF/ID instructions, holds the target until fetch accepts it, then drains for a programmable number of cycles. It also reports misaligned jump targets as an exception and keeps taken/not-taken performance counters.

## Interface
- `XLEN`, 32: datapath width, equal to `MAX_BIT_POS+1` from `config.v`.
- `FLUSH_CYCLES`, 2: post-acceptance drain cycles, range 0..15.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset. The block has one clock, and the reset polarity and synchronicity are fixed.
- `ex_valid` in 1: branch unit outputs are valid this cycle.
- `jmp_en` in 1: jump taken (from branch unit).
- `b_n_jmp` in 1: conditional branch resolved not-taken.
- `branch_hazard` in 1: the current EX instruction is a hazard bubble, so its outcome is ignored.
- `pc_cur` in XLEN: PC of the EX instruction.
- `pc_target` in XLEN: jump target (`pc_next_out` of the branch unit).
- `ext_flush` in 1: trap/interrupt flush from the CSR unit. Highest priority.
- `redirect_ready` in 1: fetch accepts the redirect.
- `ex_ready` out 1: block can take a new branch event. Upstream holds EX while this is low.
- `redirect_valid` out XLEN-qualifier 1: a redirect is pending.
- `redirect_pc` out XLEN: redirect target.
- `flush_ifid` out 1: one-cycle pulse that kills the IF and ID stage contents.
- `exc_misalign` out 1: one-cycle pulse flagging an instruction-address-misaligned exception.
- `exc_pc` out XLEN: PC of the faulting jump.
- `exc_tval` out XLEN: the misaligned target.
- `cnt_taken` out 32: count of accepted taken jumps.
- `cnt_not_taken` out 32: count of accepted not-taken branches.

## Operation
- **States:**
  - IDLE
  - REDIR: `redirect_valid` is high, waiting for `redirect_ready`.
  - DRAIN: counting down `FLUSH_CYCLES`.
- **Event** = `ex_valid & ~branch_hazard & ex_ready`.
- **IDLE with event & `jmp_en`:**
  - If `pc_target[1:0] != 0`: next cycle pulse `exc_misalign`, with `exc_pc=pc_cur` and `exc_tval=pc_target`. Stay in IDLE. No redirect, no flush, no count.
  - Else: latch `redirect_pc=pc_target`, go to REDIR, pulse `flush_ifid` on the first REDIR cycle, and increment `cnt_taken`.
- **IDLE with event & `b_n_jmp`:** increment `cnt_not_taken`. No state change.
- **REDIR:** the handshake completes on the cycle where `redirect_valid & redirect_ready` are both high.
  - `redirect_pc` is stable while valid.
  - After the handshake: if `FLUSH_CYCLES==0`, go to IDLE; else go to DRAIN with the counter loaded to `FLUSH_CYCLES`.
- **DRAIN:** decrement each cycle. Go to IDLE after the cycle in which the counter reaches 1 (exactly `FLUSH_CYCLES` DRAIN cycles).
- **`ex_ready`:** equals `state==IDLE`. Events arriving while not in IDLE are ignored and not counted.
- **`ext_flush`** (any state):
  - Next state is IDLE and `redirect_valid` drops next cycle.
  - No `exc_misalign` or `flush_ifid` pulse is generated from an event in that same cycle, and that event is not counted.
- **Counters:** wrap from `0xFFFFFFFF` to 0.
- **Defensive rule:** `jmp_en` and `b_n_jmp` both high is treated as taken.

## Timing
- All outputs are registered except `ex_ready`, which is decoded from the state register.
- **Reset values:**
  - state IDLE
  - `redirect_valid`=0, `redirect_pc`=0
  - `flush_ifid`=0, `exc_misalign`=0, `exc_pc`=0, `exc_tval`=0
  - `cnt_taken`=0, `cnt_not_taken`=0
  - `ex_ready`=1
- Reset asserted mid-REDIR/DRAIN returns to these values immediately (asynchronous); the pending redirect is lost.
- **Latency:** event in cycle C → `redirect_valid` and `flush_ifid` at C+1.
- Minimum taken-jump turnaround with `redirect_ready` tied high and `FLUSH_CYCLES=0`: `ex_ready` low at C+1 only, high at C+2.
- Counters update at C+1.

## Structure
- A shared `branch_pkg` (or `config.v` defines) holds:
  - the state encoding (IDLE=2'd0, REDIR=2'd1, DRAIN=2'd2)
  - `FLUSH_CNT_W`=4
- One natural sub-module, `perf_counter32`: a 32-bit wrap-around counter with an increment enable and async reset, instantiated twice.

## Test plan
- **Taken jump, ready high:** `pc_cur=0x100`, `pc_target=0x200`, `jmp_en=1`, `FLUSH_CYCLES=2` → C+1 `redirect_valid=1`, `redirect_pc=0x200`, `flush_ifid=1`; `ex_ready` low for C+1..C+3 and high at C+4; `cnt_taken=1`.
- **Backpressure:** `redirect_ready=0` for 5 cycles then 1 → `redirect_valid` held 6 cycles, `redirect_pc` constant, `flush_ifid` only on the first cycle; a second event during the hold is not counted.
- **Misaligned target:** `pc_target=0x202` → `exc_misalign` one cycle with `exc_tval=0x202` and `exc_pc=pc_cur`; no redirect; `cnt_taken=0`.
- **Not-taken and hazard:** `b_n_jmp=1` → `cnt_not_taken` increments; `b_n_jmp=1` with `branch_hazard=1` → no increment.
- **`ext_flush` during REDIR** → next cycle `redirect_valid=0`, state IDLE, `ex_ready=1`. `ext_flush` coincident with a taken event → no flush pulse, no count.
- **Counter wrap and reset:** preload `cnt_taken` to `0xFFFFFFFF` via repeated events (or force), then one taken event → 0. Assert `rst` mid-DRAIN → all outputs at reset values in the same cycle.
